// File: rtl/satatrn_txarb.sv
// satatrn_txarb: transport-side TX arbiter in front of the link s_* stream.
// Shares the single link TX port between the command FIS path (req 0) and
// the data FIS path (req 1). It holds the grant for a whole frame and turns
// the link's success/failed result into a done or err pulse for the owner.
// A result-wait timeout and a flush path ensure that a source never stalls.
//
// Handshake: a beat moves on any interface in the cycle where valid && ready
// are both high at the rising clock edge. Valid never waits on ready. The
// ready signals to the sources are combinational from m_ready while in SEND.
module satatrn_txarb #(
   parameter int LGTIMEOUT = 20,
   parameter bit OPT_RR    = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [32:0] s0_data,
   input  logic        s0_last,
   input  logic        s0_abort,
   output logic        s0_done,
   output logic        s0_err,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [32:0] s1_data,
   input  logic        s1_last,
   input  logic        s1_abort,
   output logic        s1_done,
   output logic        s1_err,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [32:0] m_data,
   output logic        m_last,
   output logic        m_abort,
   input  logic        i_success,
   input  logic        i_failed,
   input  logic        i_link_ready,
   input  logic        i_link_error,
   output logic [1:0]  o_grant,
   output logic        o_busy,
   output logic [1:0]  o_state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic                 owner;        // index of the current owner
   logic                 rr_pri;       // requester that wins a tie
   logic [LGTIMEOUT-1:0] timer;

   logic                 grant_take, grant_sel, timer_clr;
   logic                 own_ready, own_done, own_err;
   logic                 o_valid, o_last, o_abort, last_acc;
   logic [32:0]          o_data;

   // Only the owner's stream is visible to the sequencer.
   assign o_valid  = owner ? s1_valid : s0_valid;
   assign o_data   = owner ? s1_data  : s0_data;
   assign o_last   = owner ? s1_last  : s0_last;
   assign o_abort  = owner ? s1_abort : s0_abort;
   assign last_acc = o_valid && m_ready && o_last;

   // Next-state decode and the combinational datapath or pulse outputs.
   always_comb begin
      state_nx   = state;
      grant_take = 1'b0;
      grant_sel  = 1'b0;
      timer_clr  = 1'b0;
      own_ready  = 1'b0;
      own_done   = 1'b0;
      own_err    = 1'b0;
      m_valid    = 1'b0;
      m_data     = '0;
      m_last     = 1'b0;
      m_abort    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_link_ready && (s0_valid || s1_valid)) begin
               grant_take = 1'b1;
               state_nx   = ST_SEND;
               if (s0_valid && s1_valid)
                  grant_sel = OPT_RR ? rr_pri : 1'b0;
               else
                  grant_sel = s1_valid;
            end
         end
         ST_SEND: begin
            m_valid   = o_valid;
            m_data    = o_data;
            m_last    = o_last;
            own_ready = m_ready;
            // A terminating event that also takes the final beat has nothing
            // left to flush, so it returns straight to IDLE.
            if (i_link_error || i_failed) begin
               own_err  = 1'b1;
               state_nx = last_acc ? ST_IDLE : ST_FLUSH;
            end else if (o_abort) begin
               m_abort  = 1'b1;
               own_err  = 1'b1;
               state_nx = last_acc ? ST_IDLE : ST_FLUSH;
            end else if (last_acc) begin
               timer_clr = 1'b1;
               state_nx  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_link_error || i_failed) begin
               own_err  = 1'b1;
               state_nx = ST_IDLE;
            end else if (i_success) begin
               own_done = 1'b1;
               state_nx = ST_IDLE;
            end else if (o_abort || (timer == {LGTIMEOUT{1'b1}})) begin
               m_abort  = 1'b1;
               own_err  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            // Beats are consumed and dropped; the err pulse already went out.
            own_ready = 1'b1;
            if (o_abort || (o_valid && o_last))
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign s0_ready    = own_ready && !owner;
   assign s1_ready    = own_ready &&  owner;
   assign s0_done     = own_done  && !owner;
   assign s1_done     = own_done  &&  owner;
   assign s0_err      = own_err   && !owner;
   assign s1_err      = own_err   &&  owner;
   assign o_busy      = (state != ST_IDLE);
   assign o_state_dbg = state;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Grant ownership, and the round-robin pointer that moves at frame end.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         owner   <= 1'b0;
         o_grant <= 2'b00;
         rr_pri  <= 1'b0;
      end else if (grant_take) begin
         owner   <= grant_sel;
         o_grant <= grant_sel ? 2'b10 : 2'b01;
      end else if ((state != ST_IDLE) && (state_nx == ST_IDLE)) begin
         o_grant <= 2'b00;
         rr_pri  <= ~owner;
      end
   end

   // Result-wait timer: cleared on the last beat, counts while in WAIT.
   always_ff @(posedge i_clk) begin
      if (i_reset || timer_clr)
         timer <= '0;
      else if (state == ST_WAIT)
         timer <= timer + 1'b1;
   end

endmodule
